// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants, types and helpers for the PDM-to-PCM CIC decimator.
//   CIC_W      integrator/comb word width (two's complement, modular wrap)
//   CIC_ORDER  number of integrator and comb stages
//   OUT_SHIFT  arithmetic right shift applied to the comb output
//   state_e    decimator FSM states
//   pcm_sat    shift-and-saturate from the CIC word to a 16-bit PCM sample
package pdm_pkg;

    localparam int unsigned CIC_W      = 20;
    localparam int unsigned CIC_ORDER  = 3;
    localparam int unsigned OUT_SHIFT  = 3;
    localparam int unsigned PCM_W      = 16;
    localparam int unsigned DECIM_DEF  = 64;
    localparam int unsigned SETTLE_DEF = 3;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StRun
    } state_e;

    typedef logic signed [CIC_W-1:0] cic_t;

    localparam cic_t PCM_MAX = cic_t'(32767);
    localparam cic_t PCM_MIN = cic_t'(-32768);

    function automatic logic [PCM_W-1:0] pcm_sat(input cic_t v);
        cic_t s;
        s = v >>> OUT_SHIFT;
        if (s > PCM_MAX) begin
            return 16'h7fff;
        end else if (s < PCM_MIN) begin
            return 16'h8000;
        end
        return s[PCM_W-1:0];
    endfunction

endpackage

// File: rtl/pdm_cic_decim_if.sv
// pdm_cic_decim_if: PCM output handshake.
//   pcm_data   signed PCM sample
//   pcm_valid  pcm_data holds a sample not yet accepted
//   pcm_ready  downstream accepts pcm_data this cycle
// master = sample producer (the decimator), slave = consumer.
interface pdm_cic_decim_if;

    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;

    modport master (
        output pcm_data,
        output pcm_valid,
        input  pcm_ready
    );

    modport slave (
        input  pcm_data,
        input  pcm_valid,
        output pcm_ready
    );

endinterface

// File: rtl/pdm_sync_edge.sv
// pdm_sync_edge: brings the microphone bit clock and data into the system clock domain.
//   g_hclk_es1  system clock
//   hreset_n    asynchronous active-low reset
//   pdm_clk     microphone bit clock (asynchronous)
//   pdm_signal  microphone data (asynchronous)
//   bit_stb     one-cycle pulse per rising edge of pdm_clk, 3 cycles after the pin edge
//   bit_val     pdm_signal sampled alongside that edge
module pdm_sync_edge (
    input  logic g_hclk_es1,
    input  logic hreset_n,
    input  logic pdm_clk,
    input  logic pdm_signal,
    output logic bit_stb,
    output logic bit_val
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;
    logic       bit_stb_q;
    logic       bit_val_q;

    // Data uses the same synchronizer depth as the clock so both stay aligned.
    always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
        if (!hreset_n) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
            bit_stb_q  <= 1'b0;
            bit_val_q  <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], pdm_clk};
            dat_sync_q <= {dat_sync_q[0], pdm_signal};
            clk_prev_q <= clk_sync_q[1];
            bit_stb_q  <= clk_sync_q[1] & ~clk_prev_q;
            bit_val_q  <= dat_sync_q[1];
        end
    end

    assign bit_stb = bit_stb_q;
    assign bit_val = bit_val_q;

endmodule

// File: rtl/pdm_cic_decim.sv
// pdm_cic_decim: PDM microphone to 16-bit PCM, 3rd-order CIC decimator.
//   g_hclk_es1  system clock (rising edge)
//   hreset_n    asynchronous active-low reset
//   pdm_clk     microphone bit clock, asynchronous, <= g_hclk_es1/4
//   pdm_signal  microphone PDM data, asynchronous
//   enable      level; 1 runs the decimator, 0 returns to idle
//   clear       single-cycle pulse clearing overrun
//   overrun     sticky: a sample was dropped because the held one was not accepted
//   busy        FSM is not idle
//   pcm         master side of the PCM valid/ready handshake
module pdm_cic_decim
    import pdm_pkg::*;
#(
    parameter int unsigned DECIM  = DECIM_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic            g_hclk_es1,
    input  logic            hreset_n,
    input  logic            pdm_clk,
    input  logic            pdm_signal,
    input  logic            enable,
    input  logic            clear,
    output logic            overrun,
    output logic            busy,
    pdm_cic_decim_if.master pcm
);

    localparam int unsigned      CNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned      SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    logic bit_stb;
    logic bit_val;

    pdm_sync_edge u_sync (
        .g_hclk_es1 (g_hclk_es1),
        .hreset_n   (hreset_n),
        .pdm_clk    (pdm_clk),
        .pdm_signal (pdm_signal),
        .bit_stb    (bit_stb),
        .bit_val    (bit_val)
    );

    state_e           state_q, state_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [CNT_W-1:0] cnt_q;
    cic_t             integ_q [CIC_ORDER];
    cic_t             integ_d [CIC_ORDER];
    cic_t             dly_q   [CIC_ORDER];
    cic_t             dly_d   [CIC_ORDER];
    cic_t             diff    [CIC_ORDER];
    cic_t             x;
    cic_t             dec_q;
    logic             dec_vld_q;
    logic             run, wrap, offer, drop;
    logic [PCM_W-1:0] pcm_data_q;
    logic             pcm_valid_q;
    logic             overrun_q;

    assign run   = enable && (state_q != StIdle);
    assign wrap  = bit_stb && (cnt_q == CNT_LAST);
    assign offer = dec_vld_q && enable && (state_q == StRun);
    assign drop  = offer && pcm_valid_q && !pcm.pcm_ready;

    // Integrators chain on this bit's new values; the comb chain reads the
    // freshly updated last integrator so the wrap bit is included.
    always_comb begin
        x          = bit_val ? cic_t'(1) : cic_t'(-1);
        integ_d[0] = integ_q[0] + x;
        for (int i = 1; i < CIC_ORDER; i++) begin
            integ_d[i] = integ_q[i] + integ_d[i-1];
        end
        diff[0]  = integ_d[CIC_ORDER-1] - dly_q[0];
        dly_d[0] = integ_d[CIC_ORDER-1];
        for (int i = 1; i < CIC_ORDER; i++) begin
            diff[i]  = diff[i-1] - dly_q[i];
            dly_d[i] = diff[i-1];
        end
    end

    always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
        if (!hreset_n) begin
            integ_q   <= '{default: '0};
            dly_q     <= '{default: '0};
            cnt_q     <= '0;
            dec_q     <= '0;
            dec_vld_q <= 1'b0;
        end else if (!run) begin
            integ_q   <= '{default: '0};
            dly_q     <= '{default: '0};
            cnt_q     <= '0;
            dec_q     <= '0;
            dec_vld_q <= 1'b0;
        end else begin
            dec_vld_q <= 1'b0;
            if (bit_stb) begin
                integ_q <= integ_d;
                cnt_q   <= wrap ? '0 : cnt_q + 1'b1;
                if (wrap) begin
                    dly_q     <= dly_d;
                    dec_q     <= diff[CIC_ORDER-1];
                    dec_vld_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        unique case (state_q)
            StIdle: begin
                set_cnt_d = '0;
                if (enable) begin
                    state_d = (SETTLE == 0) ? StRun : StSettle;
                end
            end
            StSettle: begin
                if (dec_vld_q) begin
                    if (set_cnt_q == SET_LAST) begin
                        state_d   = StRun;
                        set_cnt_d = '0;
                    end else begin
                        set_cnt_d = set_cnt_q + 1'b1;
                    end
                end
            end
            StRun: ;
            default: state_d = StIdle;
        endcase
        if (!enable) begin
            state_d   = StIdle;
            set_cnt_d = '0;
        end
    end

    always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= StIdle;
            set_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            set_cnt_q <= set_cnt_d;
        end
    end

    // A new sample loads when the register is empty or being drained this
    // cycle; otherwise it is dropped and the held sample stays put.
    always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
        if (!hreset_n) begin
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
        end else if (!enable || (state_q == StIdle)) begin
            pcm_valid_q <= 1'b0;
        end else if (offer) begin
            if (!pcm_valid_q || pcm.pcm_ready) begin
                pcm_data_q  <= pcm_sat(dec_q);
                pcm_valid_q <= 1'b1;
            end
        end else if (pcm_valid_q && pcm.pcm_ready) begin
            pcm_valid_q <= 1'b0;
        end
    end

    // Set wins over clear.
    always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
        if (!hreset_n) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (clear) begin
            overrun_q <= 1'b0;
        end
    end

    assign pcm.pcm_data  = pcm_data_q;
    assign pcm.pcm_valid = pcm_valid_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: doc/pdm_cic_decim.md
PDM_CIC_DECIM -- requirements
Module: pdm_cic_decim

Interface
REQ-001 Parameter DECIM, default 64, is the decimation ratio in PDM bits per PCM sample; it SHALL be a power of two.
REQ-002 Parameter SETTLE, default 3, is the number of decimated outputs discarded after enable.
REQ-003 g_hclk_es1  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 hreset_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-005 pdm_clk  in  1  microphone bit clock, asynchronous to g_hclk_es1, at most g_hclk_es1/4.
REQ-006 pdm_signal  in  1  microphone PDM data, asynchronous.
REQ-007 enable  in  1  level; 1 runs the decimator.
REQ-008 clear  in  1  single-cycle pulse; clears overrun.
REQ-009 pcm_ready  in  1  downstream accepts pcm_data.
REQ-010 pcm_data  out  16  signed PCM sample.
REQ-011 pcm_valid  out  1  pcm_data holds an unaccepted sample.
REQ-012 overrun  out  1  sticky flag: a sample was dropped.
REQ-013 busy  out  1  state is not IDLE.

Function
REQ-014 pdm_clk and pdm_signal SHALL each pass through 2-flop synchronizers, and a rising edge of synchronized pdm_clk SHALL produce a one-cycle bit_stb.
REQ-015 On bit_stb, the synchronized pdm_signal SHALL map to +1 (1) or -1 (0) and feed a 3-stage integrator chain.
REQ-016 Integrators and combs SHALL be 20-bit two's complement with modular wrap and no saturation.
REQ-017 A decimation counter SHALL count bit_stb from 0 to DECIM-1 and wrap to 0.
REQ-018 On the wrap, the 3-stage comb chain (differential delay 1) SHALL update once from the last integrator, producing dec_out one cycle later.
REQ-019 pcm_data SHALL be dec_out arithmetic-shifted right by 3 and saturated to [-32768, +32767].
REQ-020 FSM IDLE: integrators, combs, counter and SETTLE count held at 0, and pcm_valid forced to 0; enable=1 SHALL move to SETTLE.
REQ-021 FSM SETTLE: each dec_out SHALL be discarded and counted; after SETTLE outputs the FSM SHALL move to RUN.
REQ-022 FSM RUN: each dec_out SHALL be offered to the output register.
REQ-023 enable=0 in any state SHALL return the FSM to IDLE on the next edge, discarding any pending sample.
REQ-024 Output handshake: a transfer occurs on a cycle with pcm_valid=1 and pcm_ready=1; pcm_data SHALL be stable while pcm_valid=1 and not accepted.
REQ-025 New dec_out with pcm_valid=0, or coinciding with a transfer: pcm_data SHALL load and pcm_valid SHALL be 1 next cycle.
REQ-026 New dec_out with pcm_valid=1 and pcm_ready=0: the new sample SHALL be dropped, the held sample kept, and overrun set.
REQ-027 clear SHALL zero overrun; if clear coincides with a drop event, the set SHALL win.
REQ-028 Latency from the pdm_clk rising pin edge to bit_stb SHALL be 3 g_hclk_es1 cycles; from counter wrap to pcm_valid, 2 cycles.

Reset
REQ-029 Asserting hreset_n=0 SHALL immediately set: FSM IDLE, all datapath registers 0, synchronizers 0, pcm_data=0, pcm_valid=0, overrun=0, busy=0.
REQ-030 Reset mid-RUN SHALL abandon the partial sample, and the SETTLE discard SHALL repeat after the next enable.

Structure
REQ-031 Package pdm_pkg SHALL hold CIC_W=20, CIC_ORDER=3, OUT_SHIFT=3, default DECIM/SETTLE, and the FSM state enum {IDLE, SETTLE, RUN}.
REQ-032 The synchronizers plus edge detect SHALL be sub-module pdm_sync_edge; the CIC and FSM SHALL stay in pdm_cic_decim.

Verification
REQ-033 pdm_signal=1 constant, DECIM=64, pcm_ready=1 -> after 3 discarded outputs, every pcm_data=0x7FFF and overrun=0.
REQ-034 pdm_signal=0 constant -> steady pcm_data=0x8000.
REQ-035 pdm_signal alternating 1,0 per pdm_clk -> pcm_data=0x0000 after settle.
REQ-036 pcm_ready=0 across two decimation periods -> first sample held unchanged, second dropped, overrun=1; a clear pulse -> overrun=0.
REQ-037 New sample arriving on the same cycle pcm_ready=1 accepts the old one -> pcm_valid stays 1 with the new value, overrun=0.
REQ-038 hreset_n low mid-RUN, then enable held -> all outputs 0 during reset, busy=1 after release, and the first pcm_valid appears only after (SETTLE+1)*64 PDM bits.
